// File: rtl/map_table_ctrl_if.sv
// Bundle between the rename/dispatch front end and the map-table
// controller: dispatch and retire events in, map-table commands out.
interface map_table_ctrl_if #(
   parameter int REG_SIZE = 32,
   parameter int TAG_W    = 5
);
   localparam int IDX_W = $clog2(REG_SIZE);

   logic [1:0]       disp_valid;
   logic [IDX_W-1:0] disp_rd0;
   logic [IDX_W-1:0] disp_rd1;
   logic [TAG_W-1:0] disp_tag0;
   logic [TAG_W-1:0] disp_tag1;
   logic             retire_valid;
   logic [IDX_W-1:0] retire_rd;
   logic [TAG_W-1:0] retire_tag;
   logic             squash;

   logic [1:0]       mt_we;
   logic [IDX_W-1:0] mt_wr_idx0;
   logic [IDX_W-1:0] mt_wr_idx1;
   logic [TAG_W-1:0] mt_wr_tag0;
   logic [TAG_W-1:0] mt_wr_tag1;
   logic             mt_clr_en;
   logic [IDX_W-1:0] mt_clr_idx;
   logic [TAG_W-1:0] mt_clr_tag;
   logic             mt_flush_en;
   logic [IDX_W-1:0] mt_flush_base;
   logic             dispatch_stall;
   logic             flush_done;

   // Front end / ROB side
   modport master (
      output disp_valid, disp_rd0, disp_rd1, disp_tag0, disp_tag1,
      output retire_valid, retire_rd, retire_tag, squash,
      input  mt_we, mt_wr_idx0, mt_wr_idx1, mt_wr_tag0, mt_wr_tag1,
      input  mt_clr_en, mt_clr_idx, mt_clr_tag,
      input  mt_flush_en, mt_flush_base, dispatch_stall, flush_done
   );

   // Controller side
   modport slave (
      input  disp_valid, disp_rd0, disp_rd1, disp_tag0, disp_tag1,
      input  retire_valid, retire_rd, retire_tag, squash,
      output mt_we, mt_wr_idx0, mt_wr_idx1, mt_wr_tag0, mt_wr_tag1,
      output mt_clr_en, mt_clr_idx, mt_clr_tag,
      output mt_flush_en, mt_flush_base, dispatch_stall, flush_done
   );
endinterface

// File: rtl/map_table_ctrl.sv
// map_table_ctrl: converts dual dispatch, retire and squash events into
// registered map-table write / conditional-clear / chunked-flush commands.
module map_table_ctrl #(
   parameter int REG_SIZE    = 32,
   parameter int TAG_W       = 5,
   parameter int FLUSH_CHUNK = 8
) (
   input  logic            clock,
   input  logic            reset,
   map_table_ctrl_if.slave bus
);
   localparam int IDX_W    = $clog2(REG_SIZE);
   localparam int NCHUNK   = REG_SIZE / FLUSH_CHUNK;
   localparam int CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CHUNK_SH = $clog2(FLUSH_CHUNK);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_RESUME = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_we;
   logic [IDX_W-1:0] r_wr_idx0;
   logic [IDX_W-1:0] r_wr_idx1;
   logic [TAG_W-1:0] r_wr_tag0;
   logic [TAG_W-1:0] r_wr_tag1;
   logic             r_clr_en;
   logic [IDX_W-1:0] r_clr_idx;
   logic [TAG_W-1:0] r_clr_tag;
   logic             r_flush_en;
   logic [IDX_W-1:0] r_flush_base;
   logic             r_flush_done;

   logic             w_slot0_ok;
   logic             w_slot1_ok;
   logic             w_same_rd;
   logic             w_we0;
   logic             w_we1;
   logic             w_clr;
   logic [CNT_W-1:0] w_cur_cnt;
   logic             w_last_chunk;
   logic [IDX_W-1:0] w_flush_base;

   // A slot only writes when it is valid and names a real register (r0 is never renamed)
   assign w_slot0_ok = bus.disp_valid[0] && (bus.disp_rd0 != '0);
   assign w_slot1_ok = bus.disp_valid[1] && (bus.disp_rd1 != '0);

   // Slot 1 is younger, so it owns the mapping when both target the same rd
   assign w_same_rd = w_slot0_ok && w_slot1_ok && (bus.disp_rd0 == bus.disp_rd1);
   assign w_we0     = w_slot0_ok && !w_same_rd;
   assign w_we1     = w_slot1_ok;

   // A fresh rename of the retiring rd supersedes its clear
   assign w_clr = bus.retire_valid && (bus.retire_rd != '0)
                  && !(w_we0 && (bus.disp_rd0 == bus.retire_rd))
                  && !(w_we1 && (bus.disp_rd1 == bus.retire_rd));

   // A squash during FLUSH restarts the sweep at chunk 0 in the same cycle
   assign w_cur_cnt    = bus.squash ? '0 : r_cnt;
   assign w_last_chunk = (w_cur_cnt == LAST_CNT);
   assign w_flush_base = IDX_W'(w_cur_cnt) << CHUNK_SH;

   assign bus.dispatch_stall = (r_state != ST_RUN) | bus.squash;

   assign bus.mt_we         = r_we;
   assign bus.mt_wr_idx0    = r_wr_idx0;
   assign bus.mt_wr_idx1    = r_wr_idx1;
   assign bus.mt_wr_tag0    = r_wr_tag0;
   assign bus.mt_wr_tag1    = r_wr_tag1;
   assign bus.mt_clr_en     = r_clr_en;
   assign bus.mt_clr_idx    = r_clr_idx;
   assign bus.mt_clr_tag    = r_clr_tag;
   assign bus.mt_flush_en   = r_flush_en;
   assign bus.mt_flush_base = r_flush_base;
   assign bus.flush_done    = r_flush_done;

   // Control FSM with registered one-cycle command outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_RUN;
         r_cnt        <= '0;
         r_we         <= '0;
         r_wr_idx0    <= '0;
         r_wr_idx1    <= '0;
         r_wr_tag0    <= '0;
         r_wr_tag1    <= '0;
         r_clr_en     <= 1'b0;
         r_clr_idx    <= '0;
         r_clr_tag    <= '0;
         r_flush_en   <= 1'b0;
         r_flush_base <= '0;
         r_flush_done <= 1'b0;
      end else begin
         // Commands are single-cycle; anything not reissued below drops to 0
         r_we         <= '0;
         r_wr_idx0    <= '0;
         r_wr_idx1    <= '0;
         r_wr_tag0    <= '0;
         r_wr_tag1    <= '0;
         r_clr_en     <= 1'b0;
         r_clr_idx    <= '0;
         r_clr_tag    <= '0;
         r_flush_en   <= 1'b0;
         r_flush_base <= '0;
         r_flush_done <= 1'b0;

         case (r_state)
            ST_RUN: begin
               if (bus.squash) begin
                  r_state <= ST_FLUSH;
                  r_cnt   <= '0;
               end else begin
                  r_we <= {w_we1, w_we0};
                  if (w_we0) begin
                     r_wr_idx0 <= bus.disp_rd0;
                     r_wr_tag0 <= bus.disp_tag0;
                  end
                  if (w_we1) begin
                     r_wr_idx1 <= bus.disp_rd1;
                     r_wr_tag1 <= bus.disp_tag1;
                  end
                  if (w_clr) begin
                     r_clr_en  <= 1'b1;
                     r_clr_idx <= bus.retire_rd;
                     r_clr_tag <= bus.retire_tag;
                  end
               end
            end

            ST_FLUSH: begin
               r_flush_en   <= 1'b1;
               r_flush_base <= w_flush_base;
               if (w_last_chunk) begin
                  r_flush_done <= 1'b1;
                  r_state      <= ST_RESUME;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= w_cur_cnt + CNT_W'(1);
               end
            end

            ST_RESUME: begin
               r_cnt <= '0;
               if (bus.squash) begin
                  r_state <= ST_FLUSH;
               end else begin
                  r_state <= ST_RUN;
               end
            end

            default: begin
               r_state <= ST_RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: doc/map_table_ctrl.md
MAP_TABLE_CTRL -- requirements
Module: map_table_ctrl

Interface
REQ-001 SHALL have parameters: REG_SIZE, default 32, architectural register count (power of 2); TAG_W, default 5, ROB tag width with tag 0 meaning "no tag"; FLUSH_CHUNK, default 8, map-table entries cleared per flush cycle (divides REG_SIZE).
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- disp_valid  in  2  dispatch slot valid; slot 1 is younger than slot 0
- disp_rd0, disp_rd1  in  $clog2(REG_SIZE)  destination register per slot
- disp_tag0, disp_tag1  in  TAG_W  ROB tail tag per slot
- retire_valid  in  1  head instruction retiring
- retire_rd  in  $clog2(REG_SIZE)  retiring destination register
- retire_tag  in  TAG_W  retiring ROB tag
- squash  in  1  ROB squash request, level
- mt_we  out  2  map-table write enable per slot
- mt_wr_idx0, mt_wr_idx1  out  $clog2(REG_SIZE)  write index
- mt_wr_tag0, mt_wr_tag1  out  TAG_W  write tag
- mt_clr_en  out  1  conditional clear; the map table clears the entry only if its tag equals mt_clr_tag
- mt_clr_idx  out  $clog2(REG_SIZE)  clear index
- mt_clr_tag  out  TAG_W  clear tag
- mt_flush_en  out  1  clear entries mt_flush_base .. mt_flush_base+FLUSH_CHUNK-1 to tag 0, not ready
- mt_flush_base  out  $clog2(REG_SIZE)  first entry of the flush chunk
- dispatch_stall  out  1  dispatch SHALL NOT advance while high
- flush_done  out  1  one-cycle pulse when the last chunk is issued

Function
REQ-003 SHALL implement FSM states RUN, FLUSH, RESUME.
REQ-004 SHALL register all mt_* outputs and flush_done: commands produced from cycle-N inputs appear in cycle N+1.
REQ-005 SHALL drive dispatch_stall combinationally as (state != RUN) | squash.
REQ-006 In RUN with squash=0, each valid slot with rd != 0 SHALL produce a write with its rd and tag.
REQ-007 If both slots are valid with equal nonzero rd, SHALL write only slot 1 (mt_we=2'b10).
REQ-008 If retire_valid=1 and retire_rd != 0, SHALL issue a clear with retire_rd and retire_tag, unless a dispatch write to the same rd is issued in the same cycle; in that case the clear is dropped.
REQ-009 A slot whose rd is 0 SHALL produce no write.
REQ-010 If squash=1 in RUN, SHALL issue no writes or clears for that cycle and SHALL enter FLUSH with chunk counter 0.
REQ-011 In FLUSH, each cycle SHALL issue mt_flush_en with mt_flush_base = counter*FLUSH_CHUNK, then increment the counter.
- REG_SIZE/FLUSH_CHUNK flush cycles total.
- No writes or clears are issued during FLUSH.
REQ-012 On the last chunk, SHALL pulse flush_done (registered with that chunk) and go to RESUME.
REQ-013 If squash=1 while in FLUSH, SHALL reset the counter to 0 and remain in FLUSH.
REQ-014 RESUME SHALL last exactly one cycle, issue no commands, and go to RUN; if squash=1 in RESUME, SHALL go to FLUSH with counter 0.
REQ-015 Inputs sampled in FLUSH or RESUME SHALL be ignored apart from squash.
REQ-016 Counter arithmetic SHALL be $clog2(REG_SIZE/FLUSH_CHUNK) bits wide; mt_flush_base SHALL never exceed REG_SIZE-FLUSH_CHUNK.

Reset
REQ-017 While reset=1 at a rising edge: state becomes RUN, counter 0, and all mt_* outputs and flush_done are 0.
REQ-018 dispatch_stall SHALL be 0 after reset unless squash=1.
REQ-019 Reset SHALL take priority over squash; asserting reset mid-FLUSH SHALL abort the flush without a flush_done pulse.
REQ-020 Any pending command SHALL be discarded when reset is asserted.

Verification
REQ-021 Single dispatch: slot0 valid, rd=15, tag=1 -> next cycle mt_we=01, mt_wr_idx0=15, mt_wr_tag0=1, mt_clr_en=0.
REQ-022 Dual dispatch to the same rd: rd0=rd1=11, tags 2 and 3 -> mt_we=10, idx1=11, tag1=3; with rd0=0, rd1=7 -> mt_we=10 only.
REQ-023 Retire collision: retire rd=31 tag=3 with slot0 rd=31 tag=4 -> write issued, mt_clr_en=0; retire rd=31 alone -> mt_clr_en=1, idx 31, tag 3.
REQ-024 Squash at defaults: 1-cycle squash pulse -> dispatch_stall high for 6 cycles (squash cycle + 4 FLUSH + RESUME); mt_flush_base 0,8,16,24 on consecutive cycles; flush_done coincides with base 24; no writes throughout.
REQ-025 Re-squash at the second flush cycle -> base sequence 0,0,8,16,24; flush_done exactly once.
REQ-026 Reset asserted at the third flush cycle -> all outputs 0 next cycle, no flush_done, state RUN, dispatch_stall=0.
